// File: rtl/prio_request_arbiter_pkg.sv
// Shared types and helpers for the prio_request_arbiter slice.
// PRIO_ROUND_ROBIN_EN selects round-robin instead of fixed priority.
package prio_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } prio_state_t;

    function automatic int prio_addr_w(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/prio_request_arbiter_select.sv
// Combinational winner search over a candidate vector, starting at 'start'.
// PRIO_ROUND_ROBIN_EN: ascending wrap from start; otherwise descending wrap from start.
module prio_select
    import prio_pkg::*;
#(
    parameter int N_REQ  = 8,
    parameter int ADDR_W = prio_addr_w(N_REQ)
) (
    input  logic [N_REQ-1:0]  vec,
    input  logic [ADDR_W-1:0] start,
    output logic [ADDR_W-1:0] index,
    output logic              found
);

    // Walk offsets from farthest to nearest so the nearest hit is the last write.
    always_comb begin
        index = '0;
        found = |vec;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            int                pos;
            logic [ADDR_W-1:0] p;
`ifdef PRIO_ROUND_ROBIN_EN
            pos = int'(start) + i;
            if (pos >= N_REQ) pos = pos - N_REQ;
`else
            pos = int'(start) - i;
            if (pos < 0) pos = pos + N_REQ;
`endif
            p = ADDR_W'(pos);
            if (vec[p]) index = p;
        end
    end

endmodule

// File: rtl/prio_request_arbiter.sv
// Registered request arbiter: sticky rising-edge capture, one held grant at a time.
// PRIO_ROUND_ROBIN_EN enables round-robin selection with a 'last' pointer.
module prio_request_arbiter
    import prio_pkg::*;
#(
    parameter int N_REQ  = 8,
    parameter int ADDR_W = prio_addr_w(N_REQ)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [N_REQ-1:0]  req,
    input  logic [N_REQ-1:0]  mask,
    input  logic              ack,
    output logic              valid,
    output logic [ADDR_W-1:0] address,
    output logic              any_pending,
    output logic [N_REQ-1:0]  pending_out,
    output logic              overrun
);

    prio_state_t       state_q, state_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic [N_REQ-1:0]  pending_q, pending_d;
    logic [N_REQ-1:0]  req_q;
    logic              any_pending_q, any_pending_d;
    logic              overrun_q, overrun_d;

    logic [N_REQ-1:0]  rise_w;
    logic [N_REQ-1:0]  clr_w;
    logic [N_REQ-1:0]  cand_w;
    logic [ADDR_W-1:0] start_w;
    logic [ADDR_W-1:0] sel_index_w;
    logic              sel_found_w;
    logic              accept_w;

    assign accept_w = (state_q == GRANT) && ack;
    assign cand_w   = pending_q & ~mask;

`ifdef PRIO_ROUND_ROBIN_EN
    logic [ADDR_W-1:0] last_q, last_d;

    assign last_d  = accept_w ? address_q : last_q;
    assign start_w = (last_q == ADDR_W'(N_REQ - 1)) ? '0 : last_q + ADDR_W'(1);

    always_ff @(posedge clk) begin
        if (reset) last_q <= ADDR_W'(N_REQ - 1);
        else       last_q <= last_d;
    end
`else
    assign start_w = ADDR_W'(N_REQ - 1);
`endif

    prio_select #(
        .N_REQ (N_REQ),
        .ADDR_W(ADDR_W)
    ) u_select (
        .vec  (cand_w),
        .start(start_w),
        .index(sel_index_w),
        .found(sel_found_w)
    );

    always_comb begin
        rise_w = req & ~req_q;
        clr_w  = '0;
        if (accept_w) clr_w = {{(N_REQ - 1){1'b0}}, 1'b1} << address_q;
        // A rise on the bit being acked re-arms it: set beats clear.
        pending_d     = (pending_q & ~clr_w) | rise_w;
        overrun_d     = |(rise_w & pending_q & ~clr_w);
        any_pending_d = |(pending_d & ~mask);

        state_d   = state_q;
        address_d = address_q;
        case (state_q)
            IDLE: begin
                if (enable && sel_found_w) begin
                    state_d   = GRANT;
                    address_d = sel_index_w;
                end
            end
            GRANT: begin
                if (ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // During reset req_q tracks req, so a line held high through reset is not seen as a rise.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            address_q     <= '0;
            pending_q     <= '0;
            req_q         <= req;
            any_pending_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            address_q     <= address_d;
            pending_q     <= pending_d;
            req_q         <= req;
            any_pending_q <= any_pending_d;
            overrun_q     <= overrun_d;
        end
    end

    assign valid       = (state_q == GRANT);
    assign address     = address_q;
    assign any_pending = any_pending_q;
    assign pending_out = pending_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_prio_request_arbiter.sv
// Bench for prio_request_arbiter (N_REQ=8); honours PRIO_ROUND_ROBIN_EN like the RTL.
module tb_prio_request_arbiter;

    localparam int N  = 8;
    localparam int AW = 3;
    localparam int W  = 3 + AW + N;

    logic          clk = 1'b0;
    logic          reset, enable, ack;
    logic [N-1:0]  req, mask;
    logic          valid, any_pending, overrun;
    logic [AW-1:0] address;
    logic [N-1:0]  pending_out;

    int vectors     = 0;
    int miscompares = 0;

    logic [AW-1:0] exp_q[$];

    // Reference model state: what the spec says the outputs should be.
    logic [N-1:0]  m_pend, m_reqq;
    logic          m_valid, m_any, m_ovr;
    logic [AW-1:0] m_addr;
    int            m_last;

    prio_request_arbiter #(.N_REQ(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .req        (req),
        .mask       (mask),
        .ack        (ack),
        .valid      (valid),
        .address    (address),
        .any_pending(any_pending),
        .pending_out(pending_out),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    function automatic int pick(input logic [N-1:0] cand);
`ifdef PRIO_ROUND_ROBIN_EN
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (m_last + k) % N;
            if (cand[i[AW-1:0]]) return i;
        end
`else
        for (int i = N - 1; i >= 0; i--)
            if (cand[i[AW-1:0]]) return i;
`endif
        return -1;
    endfunction

    task automatic model_edge();
        logic [N-1:0] rises, clr, nxt;
        int           p;
        if (reset) begin
            m_pend = '0; m_valid = 1'b0; m_addr = '0; m_any = 1'b0; m_ovr = 1'b0;
            m_reqq = req; m_last = N - 1;
            return;
        end
        rises = req & ~m_reqq;
        clr   = '0;
        if (m_valid && ack) clr[m_addr] = 1'b1;
        nxt   = (m_pend & ~clr) | rises;
        m_ovr = |(rises & m_pend & ~clr);
        m_any = |(nxt & ~mask);
        if (m_valid) begin
            if (ack) begin
                m_valid = 1'b0;
                m_last  = int'(m_addr);
            end
        end else if (enable) begin
            p = pick(m_pend & ~mask);
            if (p >= 0) begin
                m_valid = 1'b1;
                m_addr  = p[AW-1:0];
            end
        end
        m_pend = nxt;
        m_reqq = req;
    endtask

    function automatic logic [W-1:0] dut_vec();
        return {valid, address, any_pending, pending_out, overrun};
    endfunction

    function automatic logic [W-1:0] mdl_vec();
        return {m_valid, m_addr, m_any, m_pend, m_ovr};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; req = '0; mask = '0; ack = 1'b0; enable = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req = '1; mask = '0; ack = 1'b0; enable = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            vectors++;
            if (dut_vec() !== W'(0)) begin
                miscompares++;
                $display("FAIL reset_outputs c%0d: got %h want 0", c, dut_vec());
            end
        end
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            vectors++;
            if (valid !== 1'b0 || pending_out !== '0) begin
                miscompares++;
                $display("FAIL reset_held_high c%0d: valid %b pend %h want 0 0", c, valid, pending_out);
            end
        end
        req = 8'h00;
        tick();
        req = 8'h04;
        tick();
        req = 8'h00;
        tick();
        vectors++;
        if (valid !== 1'b1 || address !== 3'd2) begin
            miscompares++;
            $display("FAIL reset_toggle_grant: valid %b addr %0d want 1 2", valid, address);
        end
        vectors++;
        if (dut_vec() !== mdl_vec()) begin
            miscompares++;
            $display("FAIL reset_model: got %h want %h", dut_vec(), mdl_vec());
        end
    endtask

    // Acks each grant as it appears and checks addresses against exp_q.
    task automatic serve(input bit repulse, input string name);
        int            n, got, cyc;
        logic [AW-1:0] last_a, exp_a;
        n = exp_q.size(); got = 0; cyc = 0; last_a = '0;
        ack = 1'b0;
        while (got < n && cyc < 40) begin
            tick();
            cyc++;
            vectors++;
            if (dut_vec() !== mdl_vec()) begin
                miscompares++;
                $display("FAIL %s_model c%0d: got %h want %h", name, cyc, dut_vec(), mdl_vec());
            end
            req = '0;
            if (ack) begin
                ack = 1'b0;
                if (repulse) req[last_a] = 1'b1;
            end else if (valid === 1'b1) begin
                exp_a = exp_q.pop_front();
                vectors++;
                if (address !== exp_a) begin
                    miscompares++;
                    $display("FAIL %s_grant%0d: got %0d want %0d", name, got, address, exp_a);
                end
                last_a = address;
                got++;
                ack = 1'b1;
            end
        end
        if (got < n) begin
            miscompares++;
            $display("FAIL %s_timeout: got %0d grants want %0d", name, got, n);
            exp_q.delete();
        end
        tick();
        vectors++;
        if (dut_vec() !== mdl_vec()) begin
            miscompares++;
            $display("FAIL %s_final: got %h want %h", name, dut_vec(), mdl_vec());
        end
        ack = 1'b0;
        req = '0;
    endtask

    task automatic test_fixed_sequence();
        do_reset();
        req = 8'h0A;
        tick();
`ifdef PRIO_ROUND_ROBIN_EN
        exp_q = '{3'd1, 3'd3};
`else
        exp_q = '{3'd3, 3'd1};
`endif
        serve(1'b0, "seq0A");
        tick();
        vectors++;
        if (pending_out !== 8'h00 || valid !== 1'b0) begin
            miscompares++;
            $display("FAIL seq0A_drained: pend %h valid %b want 00 0", pending_out, valid);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        req = 8'h11;
        tick();
`ifdef PRIO_ROUND_ROBIN_EN
        exp_q = '{3'd0, 3'd4, 3'd0, 3'd4};
`else
        exp_q = '{3'd4, 3'd0, 3'd4, 3'd0};
`endif
        serve(1'b1, "rr11");
    endtask

    task automatic test_mask_enable();
        do_reset();
        req = 8'h80; mask = 8'h80;
        tick();
        req = 8'h00;
        for (int c = 0; c < 3; c++) begin
            tick();
            vectors++;
            if (valid !== 1'b0 || any_pending !== 1'b0 || pending_out !== 8'h80) begin
                miscompares++;
                $display("FAIL masked c%0d: valid %b any %b pend %h want 0 0 80", c, valid, any_pending, pending_out);
            end
        end
        mask = 8'h00;
        tick();
        tick();
        vectors++;
        if (valid !== 1'b1 || address !== 3'd7) begin
            miscompares++;
            $display("FAIL unmask_grant: valid %b addr %0d want 1 7", valid, address);
        end
        enable = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            vectors++;
            if (valid !== 1'b1 || address !== 3'd7) begin
                miscompares++;
                $display("FAIL enable_hold c%0d: valid %b addr %0d want 1 7", c, valid, address);
            end
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        req = 8'h04;
        vectors++;
        if (valid !== 1'b0) begin
            miscompares++;
            $display("FAIL enable_ack: valid %b want 0", valid);
        end
        tick();
        req = 8'h00;
        for (int c = 0; c < 3; c++) begin
            tick();
            vectors++;
            if (valid !== 1'b0 || any_pending !== 1'b1) begin
                miscompares++;
                $display("FAIL disabled_idle c%0d: valid %b any %b want 0 1", c, valid, any_pending);
            end
        end
        enable = 1'b1;
        tick();
        vectors++;
        if (valid !== 1'b1 || address !== 3'd2 || dut_vec() !== mdl_vec()) begin
            miscompares++;
            $display("FAIL reenable_grant: got %h want %h", dut_vec(), mdl_vec());
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic test_simultaneous();
        do_reset();
        req = 8'h20;
        tick();
        req = 8'h00;
        tick();
        vectors++;
        if (valid !== 1'b1 || address !== 3'd5) begin
            miscompares++;
            $display("FAIL sim_grant5: valid %b addr %0d want 1 5", valid, address);
        end
        ack = 1'b1; req = 8'h20;
        tick();
        ack = 1'b0; req = 8'h00;
        vectors++;
        if (valid !== 1'b0 || pending_out !== 8'h20) begin
            miscompares++;
            $display("FAIL sim_set_wins: valid %b pend %h want 0 20", valid, pending_out);
        end
        tick();
        vectors++;
        if (valid !== 1'b1 || address !== 3'd5) begin
            miscompares++;
            $display("FAIL sim_regrant5: valid %b addr %0d want 1 5", valid, address);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0; req = 8'h04;
        tick();
        req = 8'h00;
        tick();
        req = 8'h04;
        vectors++;
        if (overrun !== 1'b0 || valid !== 1'b1 || address !== 3'd2) begin
            miscompares++;
            $display("FAIL ovr_setup: ovr %b valid %b addr %0d want 0 1 2", overrun, valid, address);
        end
        tick();
        req = 8'h00;
        vectors++;
        if (overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL ovr_pulse: got %b want 1", overrun);
        end
        tick();
        vectors++;
        if (overrun !== 1'b0 || dut_vec() !== mdl_vec()) begin
            miscompares++;
            $display("FAIL ovr_one_cycle: got %h want %h", dut_vec(), mdl_vec());
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        req = 8'h40;
        tick();
        req = 8'h00;
        tick();
        vectors++;
        if (valid !== 1'b1 || address !== 3'd6) begin
            miscompares++;
            $display("FAIL mid_grant6: valid %b addr %0d want 1 6", valid, address);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++;
        if (valid !== 1'b0 || pending_out !== 8'h00) begin
            miscompares++;
            $display("FAIL mid_reset: valid %b pend %h want 0 00", valid, pending_out);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            vectors++;
            if (valid !== 1'b0) begin
                miscompares++;
                $display("FAIL mid_no_regrant c%0d: valid %b want 0", c, valid);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 2) == 0) req = N'($urandom);
            else                           req = req & N'($urandom);
            mask   = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
            enable = ($urandom_range(0, 9) != 0);
            ack    = ($urandom_range(0, 2) == 0);
            reset  = ($urandom_range(0, 99) == 0);
            tick();
            vectors++;
            if (dut_vec() !== mdl_vec()) begin
                miscompares++;
                $display("FAIL random c%0d: got %h want %h", c, dut_vec(), mdl_vec());
            end
        end
        reset = 1'b0; ack = 1'b0; req = '0; mask = '0; enable = 1'b1;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; ack = 1'b0; req = '1; mask = '0;
        m_pend = '0; m_reqq = '0; m_valid = 1'b0; m_any = 1'b0; m_ovr = 1'b0;
        m_addr = '0; m_last = N - 1;
        test_reset();
        test_fixed_sequence();
        test_round_robin();
        test_mask_enable();
        test_simultaneous();
        test_reset_mid_grant();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
